// File: rtl/instruction_decoder_if.sv
// Bus between the instruction register and the decoder: load strobe and word in,
// decoded fields out. Handshake: a word on A is taken at a rising clk whenever en=1 (no back-pressure).
interface instruction_decoder_if;
  logic        en;
  logic [15:0] A;
  logic [3:0]  OP;
  logic [2:0]  DEST;
  logic [2:0]  Q0;
  logic [2:0]  Q1;
  logic [1:0]  immed_sel;
  logic [15:0] imm;
  logic        valid;

  modport master (
    output en, A,
    input  OP, DEST, Q0, Q1, immed_sel, imm, valid
  );

  modport slave (
    input  en, A,
    output OP, DEST, Q0, Q1, immed_sel, imm, valid
  );
endinterface

// File: rtl/instruction_decoder.sv
// Registered decoder for the 16-bit instruction format: slices register fields and
// builds the sign-extended immediate for the format class implied by the opcode.
module instruction_decoder (
  input  logic                  clk,
  input  logic                  rst,
  instruction_decoder_if.slave  bus
);

  logic [3:0]  op_d, op_q;
  logic [2:0]  dest_d, dest_q;
  logic [2:0]  q0_d, q0_q;
  logic [2:0]  q1_d, q1_q;
  logic [1:0]  sel_d, sel_q;
  logic [15:0] imm_d, imm_q;
  logic        valid_q;

  always_comb begin
    op_d   = bus.A[15:12];
    dest_d = bus.A[11:9];
    q0_d   = bus.A[8:6];
    q1_d   = bus.A[5:3];
    sel_d  = 2'b00;
    imm_d  = 16'h0000;
    // Opcode ranges map onto the four formats; every opcode has a defined class.
    if (op_d[3:2] == 2'b10) begin
      sel_d = 2'b01;
      imm_d = {{10{bus.A[5]}}, bus.A[5:0]};
    end else if (op_d == 4'hC) begin
      sel_d = 2'b10;
      imm_d = {{7{bus.A[8]}}, bus.A[8:0]};
    end else if (op_d[3] && op_d[2]) begin
      sel_d = 2'b11;
      imm_d = {{4{bus.A[11]}}, bus.A[11:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      dest_q  <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      sel_q   <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en;
      // Fields hold their last decode when not loading; only valid drops.
      if (bus.en) begin
        op_q   <= op_d;
        dest_q <= dest_d;
        q0_q   <= q0_d;
        q1_q   <= q1_d;
        sel_q  <= sel_d;
        imm_q  <= imm_d;
      end
    end
  end

  assign bus.OP        = op_q;
  assign bus.DEST      = dest_q;
  assign bus.Q0        = q0_q;
  assign bus.Q1        = q1_q;
  assign bus.immed_sel = sel_q;
  assign bus.imm       = imm_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed test-plan rows, async reset, hold and
// random streams checked against an arithmetic reference model.
module tb_instruction_decoder;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] exp_q[$];
  logic [30:0]  model_fields;
  logic         model_valid;

  instruction_decoder_if bus ();

  instruction_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  // reference model: fields by integer division/modulo, immediates by signed arithmetic
  function automatic logic [30:0] ref_decode(input int a);
    int op, dest, q0, q1, sel, v;
    op   = a / 4096;
    dest = (a / 512) % 8;
    q0   = (a / 64) % 8;
    q1   = (a / 8) % 8;
    if (op < 8) begin
      sel = 0; v = 0;
    end else if (op < 12) begin
      sel = 1; v = a % 64;   if (v >= 32)   v = v - 64;
    end else if (op == 12) begin
      sel = 2; v = a % 512;  if (v >= 256)  v = v - 512;
    end else begin
      sel = 3; v = a % 4096; if (v >= 2048) v = v - 4096;
    end
    if (v < 0) v = v + 65536;
    return {op[3:0], dest[2:0], q0[2:0], q1[2:0], sel[1:0], v[15:0]};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.OP, bus.DEST, bus.Q0, bus.Q1, bus.immed_sel, bus.imm, bus.valid};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", tag, obs, exp);
    end
  endtask

  // driver: present inputs at negedge, model the edge, compare after it
  task automatic step(input string tag, input logic en, input logic [15:0] a);
    @(negedge clk);
    bus.en = en;
    bus.A  = a;
    if (en) model_fields = ref_decode(int'(a));
    model_valid = en;
    exp_q.push_back({model_fields, model_valid});
    @(posedge clk);
    #1;
    check(tag, observed(), exp_q.pop_front());
  endtask

  task automatic model_reset();
    model_fields = '0;
    model_valid  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.A  = 16'hFFE1;
    model_reset();
    #1;
    check("reset_async", observed(), '0);
    @(posedge clk);
    #1;
    check("reset_edge", observed(), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release", observed(), '0);

    step("row_FFE1_first", 1'b1, 16'hFFE1);
    check("row_FFE1_const", observed(), {4'hF, 3'd7, 3'd7, 3'd4, 2'b11, 16'hFFE1, 1'b1});
    step("row_0000", 1'b1, 16'h0000);
    check("row_0000_const", observed(), {4'h0, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000, 1'b1});
    step("row_ABCD", 1'b1, 16'hABCD);
    check("row_ABCD_const", observed(), {4'hA, 3'd5, 3'd7, 3'd1, 2'b01, 16'h000D, 1'b1});
    step("row_AE13", 1'b1, 16'hAE13);
    check("row_AE13_const", observed(), {4'hA, 3'd7, 3'd0, 3'd2, 2'b01, 16'h0013, 1'b1});
    step("row_FFE1", 1'b1, 16'hFFE1);
    step("row_C1FF", 1'b1, 16'hC1FF);
    check("row_C1FF_imm", {14'd0, bus.immed_sel, bus.imm}, {14'd0, 2'b10, 16'hFFFF});
    step("row_8020", 1'b1, 16'h8020);
    check("row_8020_imm", {14'd0, bus.immed_sel, bus.imm}, {14'd0, 2'b01, 16'hFFE0});

    step("hold_load", 1'b1, 16'hABCD);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 16'h0000);
    check("hold_const", observed(), {4'hA, 3'd5, 3'd7, 3'd1, 2'b01, 16'h000D, 1'b0});

    step("b2b_0000", 1'b1, 16'h0000);
    step("b2b_ABCD", 1'b1, 16'hABCD);
    step("b2b_AE13", 1'b1, 16'hAE13);

    // mid-stream reset: clears at once and discards the word pending at the next edge
    @(negedge clk);
    bus.en = 1'b1;
    bus.A  = 16'hD7A5;
    rst    = 1'b1;
    model_reset();
    #1;
    check("midrst_async", observed(), '0);
    @(posedge clk);
    #1;
    check("midrst_edge", observed(), '0);
    @(negedge clk);
    rst = 1'b0;
    step("after_rst", 1'b1, 16'h5A5A);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 16'($urandom));
      // input changes between edges must not reach the outputs
      bus.A  = 16'($urandom);
      bus.en = 1'($urandom_range(0, 1));
      #2;
      check("rand_stable", observed(), {model_fields, model_valid});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
